addsub_arbiter: RTL and testbench
=================================

Name: addsub_arbiter

Overview:
- Shares one 32-bit ripple add/subtract datapath between two requesters.
- Supported operations: add, sub and set-less-than (slt).
- Arbitrates round-robin and latches the winner's operands.
- Holds the operands stable on the datapath for a fixed settle window, since the gate-level ripple chain needs several cycles. It then captures sum/carry/overflow and returns them over a valid/ready response channel tagged with the requester id.

Parameters:
WIDTH, 32, operand/result width
SETTLE_CYCLES, 4, clock cycles operands are held before the datapath outputs are sampled; legal range 1..255

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  synchronous reset, active low
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_op  input  2  00 add, 01 sub, 10 slt, 11 reserved
req0_a  input  WIDTH  operand A
req0_b  input  WIDTH  operand B
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
dp_a  output  WIDTH  operand A to shared datapath
dp_b  output  WIDTH  operand B to shared datapath
dp_sub  output  1  subtract enable to datapath (invert B, carry-in 1)
dp_sum  input  WIDTH  datapath sum
dp_carryout  input  1  datapath carry out
dp_overflow  input  1  datapath signed overflow
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_id  output  1  requester that issued the operation
rsp_result  output  WIDTH  result
rsp_carryout  output  1  captured carry out
rsp_overflow  output  1  captured overflow
rsp_err  output  1  reserved opcode was issued

Behaviour:
- Reset: rst_n low at a rising edge forces the following state; this holds also mid-operation, where any in-flight operation and pending response are discarded.
  - state IDLE, rsp_valid 0, rsp_id/rsp_result/rsp_carryout/rsp_overflow/rsp_err 0.
  - dp_a/dp_b 0, dp_sub 0, settle counter 0, last_grant 1 (requester 0 wins first tie).
- States: IDLE, SETTLE, RESPOND.
- Grant logic (combinational, IDLE only):
  - grant0 = req0_valid & (~req1_valid | last_grant==1).
  - grant1 = req1_valid & ~grant0.
  - reqN_ready = (state==IDLE) & grantN. Ready is 0 in SETTLE and RESPOND.
  - Requesters must not make valid depend on ready.
  - Once valid is asserted, operands and op are held until ready.
- Accept edge (IDLE, some grant):
  - Latch a, b, op and id into dp_a, dp_b, the op register and the id register.
  - dp_sub = 1 for op 01/10, 0 for 00/11.
  - last_grant = id; counter = SETTLE_CYCLES-1; go to SETTLE.
- SETTLE:
  - dp_a/dp_b/dp_sub held constant.
  - Counter != 0: decrement.
  - Counter == 0: at that edge capture the response and go to RESPOND, with rsp_valid=1.
    - add/sub: rsp_result = dp_sum.
    - slt: rsp_result = {WIDTH-1 zeros, dp_sum[WIDTH-1] ^ dp_overflow} (signed A<B).
    - Reserved: rsp_result = 0, rsp_err = 1; otherwise rsp_err = 0.
    - rsp_carryout/rsp_overflow are taken from the datapath for every op, including slt.
- Latency: rsp_valid rises exactly SETTLE_CYCLES edges after the accept edge.
- RESPOND:
  - rsp_* held stable while rsp_valid & ~rsp_ready.
  - Handshake edge (rsp_ready=1): rsp_valid=0, go to IDLE. rsp_result etc. keep their last value.
- Throughput: with rsp_ready tied high, one operation per SETTLE_CYCLES+2 cycles. The next accept happens on the edge after returning to IDLE.
- Fairness: under continuous contention grants strictly alternate, so no requester waits more than one foreign operation.
- Arithmetic: all modulo 2^WIDTH. The controller performs no arithmetic itself except the slt bit.

Test Plan:
- Single add: req0 a=0x00000005, b=0x00000003, op 00 -> accept edge E0; rsp_valid at E4 (SETTLE_CYCLES=4); rsp_id 0, result 0x00000008, carryout 0, overflow 0, err 0.
- Sub/overflow: req1 a=0x80000000, b=0x00000001, op 01 -> dp_sub=1 throughout SETTLE; result 0x7FFFFFFF, overflow 1, carryout 1, rsp_id 1.
- slt signed: req0 a=0xFFFFFFFE (-2), b=0x00000003, op 10 -> result 0x00000001. Swapping operands -> 0x00000000.
- Contention: both valid continuously, rsp_ready=1, four ops -> grant order 0,1,0,1; accepts 6 cycles apart; rsp_id sequence 0,1,0,1.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp fields stable, req ready stays 0, no new accept. rsp_ready=1 -> IDLE next edge.
- Reset mid-op: rst_n low at the 2nd SETTLE cycle -> next edge IDLE, rsp_valid 0, dp_* 0. The op is not returned; the next tie grants requester 0.

Source files
------------

// File: rtl/addsub_arbiter_if.sv
//------------------------------------------------------------------------------
// Module      : addsub_arbiter_if
// Description : Bundles the two requester channels, the shared datapath hookup
//               and the response channel of the add/sub arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface addsub_arbiter_if #(
  parameter int WIDTH = 32
);
  // requester 0
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  // requester 1
  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  // shared ripple datapath
  logic [WIDTH-1:0] dp_a;
  logic [WIDTH-1:0] dp_b;
  logic             dp_sub;
  logic [WIDTH-1:0] dp_sum;
  logic             dp_carryout;
  logic             dp_overflow;
  // response channel
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carryout;
  logic             rsp_overflow;
  logic             rsp_err;

  // arbiter side
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output dp_a, dp_b, dp_sub,
    input  dp_sum, dp_carryout, dp_overflow,
    output rsp_valid, rsp_id, rsp_result, rsp_carryout, rsp_overflow, rsp_err,
    input  rsp_ready
  );

  // requesters, datapath and consumer side
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  dp_a, dp_b, dp_sub,
    output dp_sum, dp_carryout, dp_overflow,
    input  rsp_valid, rsp_id, rsp_result, rsp_carryout, rsp_overflow, rsp_err,
    output rsp_ready
  );
endinterface

`default_nettype wire

// File: rtl/addsub_arbiter.sv
//------------------------------------------------------------------------------
// Module      : addsub_arbiter
// Description : Round-robin arbiter sharing one ripple add/sub datapath between
//               two requesters; holds operands for a settle window, then
//               returns sum/carry/overflow (or the slt bit) tagged with the id.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module addsub_arbiter #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  addsub_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SLT = 2'b10;
  // counter is loaded with SETTLE_CYCLES-1 so the capture lands exactly
  // SETTLE_CYCLES edges after the accept edge
  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic [7:0]       cnt;
  logic             last_grant;
  logic [1:0]       op_q;
  logic             id_q;
  logic             grant0;
  logic             grant1;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] dp_a_q;
  logic [WIDTH-1:0] dp_b_q;
  logic             dp_sub_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_carryout_q;
  logic             rsp_overflow_q;
  logic             rsp_err_q;

  // requester 0 wins when alone or when requester 1 was served last
  assign grant0 = (state == IDLE) & bus.req0_valid & (~bus.req1_valid | last_grant);
  assign grant1 = (state == IDLE) & bus.req1_valid & ~grant0;
  assign sel_op = grant0 ? bus.req0_op : bus.req1_op;

  assign bus.req0_ready   = grant0;
  assign bus.req1_ready   = grant1;
  assign bus.dp_a         = dp_a_q;
  assign bus.dp_b         = dp_b_q;
  assign bus.dp_sub       = dp_sub_q;
  assign bus.rsp_valid    = (state == RESPOND);
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_carryout = rsp_carryout_q;
  assign bus.rsp_overflow = rsp_overflow_q;
  assign bus.rsp_err      = rsp_err_q;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant0 | grant1) next_state = SETTLE;
      SETTLE:  if (cnt == 8'd0)     next_state = RESPOND;
      RESPOND: if (bus.rsp_ready)   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // operand latch, settle counter and response capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dp_a_q         <= '0;
      dp_b_q         <= '0;
      dp_sub_q       <= 1'b0;
      op_q           <= OP_ADD;
      id_q           <= 1'b0;
      cnt            <= 8'd0;
      last_grant     <= 1'b1;
      rsp_id_q       <= 1'b0;
      rsp_result_q   <= '0;
      rsp_carryout_q <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 | grant1) begin
            dp_a_q     <= grant0 ? bus.req0_a : bus.req1_a;
            dp_b_q     <= grant0 ? bus.req0_b : bus.req1_b;
            dp_sub_q   <= (sel_op == OP_SUB) || (sel_op == OP_SLT);
            op_q       <= sel_op;
            id_q       <= grant1;
            last_grant <= grant1;
            cnt        <= SETTLE_INIT;
          end
        end
        SETTLE: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            rsp_id_q       <= id_q;
            rsp_carryout_q <= bus.dp_carryout;
            rsp_overflow_q <= bus.dp_overflow;
            rsp_err_q      <= 1'b0;
            case (op_q)
              OP_ADD, OP_SUB: rsp_result_q <= bus.dp_sum;
              // signed less-than: sign of A-B corrected by overflow
              OP_SLT: rsp_result_q <= {{(WIDTH-1){1'b0}},
                                       bus.dp_sum[WIDTH-1] ^ bus.dp_overflow};
              default: begin
                rsp_result_q <= '0;
                rsp_err_q    <= 1'b1;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_addsub_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_addsub_arbiter
// Description : Directed self-checking bench for addsub_arbiter, with a
//               behavioural ripple datapath hooked to the dp_* signals.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_addsub_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  addsub_arbiter_if #(.WIDTH(32)) bus ();

  addsub_arbiter #(.WIDTH(32), .SETTLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural datapath: a + (sub ? ~b : b) + sub
  logic [31:0] bx;
  logic [32:0] ext;
  assign bx              = bus.dp_sub ? ~bus.dp_b : bus.dp_b;
  assign ext             = {1'b0, bus.dp_a} + {1'b0, bx} + {32'd0, bus.dp_sub};
  assign bus.dp_sum      = ext[31:0];
  assign bus.dp_carryout = ext[32];
  assign bus.dp_overflow = (bus.dp_a[31] == bx[31]) && (ext[31] != bus.dp_a[31]);

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 1'b0;
    tick(2);
    rst_n = 1'b1;

    // reset state
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_result", bus.rsp_result, 32'd0);
    check("rst_dp_a", bus.dp_a, 32'd0);
    check("rst_dp_sub", 32'(bus.dp_sub), 32'd0);

    // single add from requester 0
    bus.req0_valid = 1'b1; bus.req0_op = 2'b00;
    bus.req0_a = 32'h0000_0005; bus.req0_b = 32'h0000_0003;
    #1;
    check("add_ready0", 32'(bus.req0_ready), 32'd1);
    tick(1);                                   // E0 accept
    bus.req0_valid = 1'b0;
    check("add_dp_a", bus.dp_a, 32'h5);
    check("add_dp_sub", 32'(bus.dp_sub), 32'd0);
    tick(3);                                   // E3
    check("add_not_early", 32'(bus.rsp_valid), 32'd0);
    tick(1);                                   // E4
    check("add_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("add_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("add_result", bus.rsp_result, 32'h0000_0008);
    check("add_carry", 32'(bus.rsp_carryout), 32'd0);
    check("add_ovf", 32'(bus.rsp_overflow), 32'd0);
    check("add_err", 32'(bus.rsp_err), 32'd0);
    bus.rsp_ready = 1'b1;
    tick(1);
    check("add_done", 32'(bus.rsp_valid), 32'd0);

    // sub with signed overflow from requester 1
    bus.req1_valid = 1'b1; bus.req1_op = 2'b01;
    bus.req1_a = 32'h8000_0000; bus.req1_b = 32'h0000_0001;
    #1;
    check("sub_ready1", 32'(bus.req1_ready), 32'd1);
    tick(1);
    bus.req1_valid = 1'b0;
    check("sub_dp_sub_e0", 32'(bus.dp_sub), 32'd1);
    tick(2);
    check("sub_dp_sub_e2", 32'(bus.dp_sub), 32'd1);
    tick(2);
    check("sub_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("sub_result", bus.rsp_result, 32'h7FFF_FFFF);
    check("sub_ovf", 32'(bus.rsp_overflow), 32'd1);
    check("sub_carry", 32'(bus.rsp_carryout), 32'd1);
    check("sub_rsp_id", 32'(bus.rsp_id), 32'd1);
    tick(1);

    // slt -2 < 3, then backpressure while the swapped slt waits
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = 2'b10;
    bus.req0_a = 32'hFFFF_FFFE; bus.req0_b = 32'h0000_0003;
    tick(1);
    bus.req0_a = 32'h0000_0003; bus.req0_b = 32'hFFFF_FFFE;
    tick(4);
    check("slt_result", bus.rsp_result, 32'h0000_0001);
    check("slt_err", 32'(bus.rsp_err), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_result", bus.rsp_result, 32'h0000_0001);
      check("bp_ready0", 32'(bus.req0_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick(1);
    check("bp_release", 32'(bus.rsp_valid), 32'd0);
    check("bp_idle_ready0", 32'(bus.req0_ready), 32'd1);
    check("bp_result_kept", bus.rsp_result, 32'h0000_0001);
    tick(1);                                   // accept swapped slt
    bus.req0_valid = 1'b0;
    tick(4);
    check("slt_swap_result", bus.rsp_result, 32'h0000_0000);
    tick(1);

    // reserved opcode
    bus.req1_valid = 1'b1; bus.req1_op = 2'b11;
    bus.req1_a = 32'h1234_5678; bus.req1_b = 32'h1111_1111;
    tick(1);
    bus.req1_valid = 1'b0;
    tick(4);
    check("rsv_err", 32'(bus.rsp_err), 32'd1);
    check("rsv_result", bus.rsp_result, 32'd0);
    tick(1);

    // reset during SETTLE: requester 0 op, then rst_n low in 2nd settle cycle
    bus.req0_valid = 1'b1; bus.req0_op = 2'b00;
    bus.req0_a = 32'h0000_0010; bus.req0_b = 32'h0000_0020;
    tick(1);
    bus.req0_valid = 1'b0;
    tick(1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("rstmid_valid", 32'(bus.rsp_valid), 32'd0);
    check("rstmid_dp_a", bus.dp_a, 32'd0);
    check("rstmid_dp_b", bus.dp_b, 32'd0);
    tick(5);
    check("rstmid_no_rsp", 32'(bus.rsp_valid), 32'd0);

    // contention: both valid, ready high, expect 0,1,0,1 six cycles apart
    bus.req0_valid = 1'b1; bus.req0_op = 2'b00;
    bus.req0_a = 32'd10; bus.req0_b = 32'd20;
    bus.req1_valid = 1'b1; bus.req1_op = 2'b01;
    bus.req1_a = 32'd100; bus.req1_b = 32'd1;
    bus.rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("cont_ready0", 32'(bus.req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      check("cont_ready1", 32'(bus.req1_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
      tick(4);
      check("cont_not_early", 32'(bus.rsp_valid), 32'd0);
      tick(1);
      check("cont_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("cont_rsp_id", 32'(bus.rsp_id), 32'(k % 2));
      check("cont_result", bus.rsp_result, (k % 2 == 0) ? 32'd30 : 32'd99);
      tick(1);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
